fence_flush_sequencer: RTL
==========================

// Module: fence_flush_sequencer
// PURPOSE
//  Sequences the flush side-effects of committed fence-class instructions (csr write, fence, sfence.vma, fence.i).
//  Accepts one request at a time from the commit-stage fence logic.
//  Drives the store-buffer drain, the per-TLB MMU flush and the icache flush in a fixed order.
//  Reports completion with a single fence_end pulse tagged with the request robIdx.
// PARAMETERS
//  NUM_TLB   3    number of TLBs flushed by sfence.vma (itlb, dtlb, l2tlb)
//  ROB_W     `ROB_WIDTH  robIdx width
//  VADDR_W   `VADDR_SIZE sfence.vma address width
//  ASID_W    `TLB_ASID   sfence.vma asid width
// PORTS
//  clk             in   1        clock
//  rst             in   1        reset, asynchronous, active-low
//  req_valid       in   1        fence request from commit
//  req_ready       out  1        request accepted this cycle when valid&ready
//  req_type        in   2        0 csr, 1 fence, 2 sfence.vma, 3 fence.i
//  req_robidx      in   ROB_W    robIdx of the fence instruction
//  req_vaddr       in   VADDR_W  sfence.vma rs1 value
//  req_asid        in   ASID_W   sfence.vma rs2 value
//  store_flush     out  1        level: drain store queue/buffer
//  store_flush_end in   1        drain complete, sampled only while store_flush=1
//  mmu_flush       out  NUM_TLB  one-cycle pulse per TLB
//  mmu_flush_end   in   NUM_TLB  per-TLB ack pulses, any order
//  mmu_flush_all   out  1        latched req_vaddr==0
//  vma_vaddr       out  VADDR_W  latched req_vaddr
//  vma_asid        out  ASID_W   latched req_asid
//  inst_flush      out  1        level: icache flush (FENCEI_FLUSH_EN only)
//  inst_flush_end  in   1        icache flush complete
//  fence_end       out  1        one-cycle completion pulse
//  fence_robidx    out  ROB_W    robIdx of completing request, valid with fence_end
//  busy            out  1        state!=IDLE
// BEHAVIOUR
//  - States: IDLE, STORE, MMU, INST, DONE. All outputs registered or decoded from the registered state.
//  - Reset: state=IDLE, ack_mask=0, all outputs 0 except req_ready=1.
//  - req_ready=1 only in IDLE. On accept, latch type, robidx, vaddr, asid, and vaddr==0.
//    - csr -> DONE.
//    - fence, sfence.vma, fence.i -> STORE.
//  - STORE: store_flush=1. When store_flush_end=1:
//    - fence -> DONE; sfence.vma -> MMU; fence.i -> INST.
//  - MMU:
//    - mmu_flush={NUM_TLB{1}} on the first MMU cycle only.
//    - ack_mask |= mmu_flush_end every MMU cycle, including the pulse cycle.
//    - Leave for DONE when (ack_mask|mmu_flush_end) is all ones. Clear ack_mask on exit.
//  - INST: inst_flush=1 until inst_flush_end=1, then -> DONE.
//  - DONE: fence_end=1 and fence_robidx=latched robidx for exactly one cycle, then -> IDLE.
//    - req_ready=0 in DONE, so a back-to-back request is accepted in the following IDLE cycle.
//  - Latency from accept cycle T:
//    - csr: fence_end at T+1.
//    - fence: fence_end one cycle after the store_flush_end cycle.
//  - Ends and acks outside their own state are ignored. Duplicate TLB acks are harmless.
//  - Reset asserted mid-operation aborts the sequence: state=IDLE, levels drop, no fence_end.
// CONFIGURATION
//  FENCEI_FLUSH_EN defined:
//    - type 3 runs STORE then INST.
//  FENCEI_FLUSH_EN undefined:
//    - type 3 is handled as fence (STORE then DONE); INST is unreachable.
//    - inst_flush is tied 0; inst_flush_end is unused.
// TESTING
//  - csr request robidx=5 at T -> req_ready=0 at T+1; fence_end=1 with fence_robidx=5 at T+1 only; no flush outputs.
//  - fence at T, store_flush_end at T+4 -> store_flush=1 T+1..T+4; fence_end at T+5; mmu_flush never asserted.
//  - sfence.vma vaddr=0, asid=3 -> after store_flush_end, mmu_flush=3'b111 for 1 cycle; mmu_flush_all=1, vma_asid=3.
//    Acks 3'b010, then 3'b101 two cycles later -> fence_end one cycle after the 3'b101 ack.
//  - sfence.vma vaddr=0x1000 with all acks in the pulse cycle -> mmu_flush_all=0; fence_end on the next cycle.
//  - fence.i with FENCEI_FLUSH_EN -> store_flush, then inst_flush until inst_flush_end, then fence_end.
//    Without the macro -> inst_flush stays 0; fence_end right after store drain.
//  - Reset pulse while in MMU with ack_mask=3'b001 -> all outputs at reset values.
//    A new sfence then needs all three fresh acks.

Source files
------------

// File: rtl/fence_flush_sequencer.sv
// fence_flush_sequencer: runs the flush side-effects of committed fence-class
// instructions (csr, fence, sfence.vma, fence.i) one request at a time:
// store drain, then per-TLB MMU flush or icache flush, then a tagged fence_end.
// Optional feature macro: FENCEI_FLUSH_EN (fence.i also flushes the icache).

`ifndef ROB_WIDTH
`define ROB_WIDTH 8
`endif
`ifndef VADDR_SIZE
`define VADDR_SIZE 39
`endif
`ifndef TLB_ASID
`define TLB_ASID 16
`endif

module fence_flush_sequencer #(
    parameter int unsigned NUM_TLB = 3,
    parameter int unsigned ROB_W   = `ROB_WIDTH,
    parameter int unsigned VADDR_W = `VADDR_SIZE,
    parameter int unsigned ASID_W  = `TLB_ASID
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [1:0]         req_type_i,
    input  logic [ROB_W-1:0]   req_robidx_i,
    input  logic [VADDR_W-1:0] req_vaddr_i,
    input  logic [ASID_W-1:0]  req_asid_i,
    output logic               store_flush_o,
    input  logic               store_flush_end_i,
    output logic [NUM_TLB-1:0] mmu_flush_o,
    input  logic [NUM_TLB-1:0] mmu_flush_end_i,
    output logic               mmu_flush_all_o,
    output logic [VADDR_W-1:0] vma_vaddr_o,
    output logic [ASID_W-1:0]  vma_asid_o,
    output logic               inst_flush_o,
    input  logic               inst_flush_end_i,
    output logic               fence_end_o,
    output logic [ROB_W-1:0]   fence_robidx_o,
    output logic               busy_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_STORE = 3'd1;
    localparam logic [2:0] S_MMU   = 3'd2;
    localparam logic [2:0] S_INST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] T_CSR    = 2'd0;
    localparam logic [1:0] T_FENCE  = 2'd1;
    localparam logic [1:0] T_SFENCE = 2'd2;
    localparam logic [1:0] T_FENCEI = 2'd3;

    logic [2:0]         state_q, state_d;
    logic [1:0]         typ_q, typ_d;
    logic [ROB_W-1:0]   rob_q, rob_d;
    logic [VADDR_W-1:0] vaddr_q, vaddr_d;
    logic [ASID_W-1:0]  asid_q, asid_d;
    logic               all_q, all_d;
    logic [NUM_TLB-1:0] ack_q, ack_d;

    logic               req_ready_q;
    logic               store_flush_q;
    logic [NUM_TLB-1:0] mmu_flush_q;
    logic               fence_end_q;
    logic [ROB_W-1:0]   fence_robidx_q;
    logic               busy_q;

    // State and request-context registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            typ_q   <= T_CSR;
            rob_q   <= '0;
            vaddr_q <= '0;
            asid_q  <= '0;
            all_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            typ_q   <= typ_d;
            rob_q   <= rob_d;
            vaddr_q <= vaddr_d;
            asid_q  <= asid_d;
            all_q   <= all_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state, request latching and TLB ack accumulation
    always_comb begin
        state_d = state_q;
        typ_d   = typ_q;
        rob_d   = rob_q;
        vaddr_d = vaddr_q;
        asid_d  = asid_q;
        all_d   = all_q;
        ack_d   = ack_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    typ_d   = req_type_i;
                    rob_d   = req_robidx_i;
                    vaddr_d = req_vaddr_i;
                    asid_d  = req_asid_i;
                    all_d   = (req_vaddr_i == '0);
                    state_d = (req_type_i == T_CSR) ? S_DONE : S_STORE;
                end
            end
            S_STORE: begin
                if (store_flush_end_i) begin
                    case (typ_q)
                        T_SFENCE: state_d = S_MMU;
`ifdef FENCEI_FLUSH_EN
                        T_FENCEI: state_d = S_INST;
`endif
                        default:  state_d = S_DONE;
                    endcase
                end
            end
            S_MMU: begin
                // Acks may arrive in any order, including the pulse cycle
                ack_d = ack_q | mmu_flush_end_i;
                if (&ack_d) begin
                    ack_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_INST: begin
`ifdef FENCEI_FLUSH_EN
                if (inst_flush_end_i) begin
                    state_d = S_DONE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs registered from the next state so they line up with state_q
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_ready_q    <= 1'b1;
            store_flush_q  <= 1'b0;
            mmu_flush_q    <= '0;
            fence_end_q    <= 1'b0;
            fence_robidx_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            req_ready_q    <= (state_d == S_IDLE);
            store_flush_q  <= (state_d == S_STORE);
            mmu_flush_q    <= ((state_d == S_MMU) && (state_q != S_MMU)) ? {NUM_TLB{1'b1}} : '0;
            fence_end_q    <= (state_d == S_DONE);
            fence_robidx_q <= (state_d == S_DONE) ? rob_d : '0;
            busy_q         <= (state_d != S_IDLE);
        end
    end

`ifdef FENCEI_FLUSH_EN
    logic inst_flush_q;

    // Icache flush level, high for the whole INST state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inst_flush_q <= 1'b0;
        end else begin
            inst_flush_q <= (state_d == S_INST);
        end
    end

    assign inst_flush_o = inst_flush_q;
`else
    logic unused_inst_flush_end;

    assign unused_inst_flush_end = inst_flush_end_i;
    assign inst_flush_o          = 1'b0;
`endif

    assign req_ready_o     = req_ready_q;
    assign store_flush_o   = store_flush_q;
    assign mmu_flush_o     = mmu_flush_q;
    assign mmu_flush_all_o = all_q;
    assign vma_vaddr_o     = vaddr_q;
    assign vma_asid_o      = asid_q;
    assign fence_end_o     = fence_end_q;
    assign fence_robidx_o  = fence_robidx_q;
    assign busy_o          = busy_q;

endmodule
